// File: rtl/hc_queue_pkg.sv
// Shared types and defaults for the hybrid-cache queues.
// Level width helper, default geometry and the sticky error-flag record.
package hc_queue_pkg;

    localparam int HC_DATABITS     = 8;
    localparam int HC_QUEUECNTBITS = 4;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } hc_err_t;

    // One extra bit so that a completely full queue has its own level code.
    function automatic int level_bits(input int cntbits);
        return cntbits + 1;
    endfunction

endpackage

// File: rtl/hc_queue_if.sv
// Push/pop/status bundle of hc_queue; master is the producer/consumer side,
// slave is the queue itself.
interface hc_queue_if
    import hc_queue_pkg::*;
#(
    parameter int DATABITS     = HC_DATABITS,
    parameter int QUEUECNTBITS = HC_QUEUECNTBITS
);

    logic [DATABITS-1:0]                 queue_in;
    logic                                queue_push;
    logic                                queue_full;
    logic                                queue_warning;
    logic                                queue_pop;
    logic [DATABITS-1:0]                 queue_out;
    logic                                queue_not_empty;
    logic [level_bits(QUEUECNTBITS)-1:0] queue_level;
    logic                                queue_overflow;
    logic                                queue_underflow;
    logic                                queue_clr_err;

    modport master (
        output queue_in, queue_push, queue_pop, queue_clr_err,
        input  queue_full, queue_warning, queue_out, queue_not_empty,
        input  queue_level, queue_overflow, queue_underflow
    );

    modport slave (
        input  queue_in, queue_push, queue_pop, queue_clr_err,
        output queue_full, queue_warning, queue_out, queue_not_empty,
        output queue_level, queue_overflow, queue_underflow
    );

endinterface

// File: rtl/hc_queue_ram.sv
// Simple dual-port storage for hc_queue. Read is asynchronous by default and
// registered (with read enable) when HC_QUEUE_REGOUT_EN is defined.
module hc_queue_ram #(
    parameter int DATABITS = 8,
    parameter int ADDRBITS = 4
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDRBITS-1:0] wr_addr,
    input  logic [DATABITS-1:0] wr_data,
`ifdef HC_QUEUE_REGOUT_EN
    input  logic                rd_en,
`endif
    input  logic [ADDRBITS-1:0] rd_addr,
    output logic [DATABITS-1:0] rd_data
);

    logic [DATABITS-1:0] mem [0:(1<<ADDRBITS)-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

`ifdef HC_QUEUE_REGOUT_EN
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end
`else
    assign rd_data = mem[rd_addr];
`endif

endmodule

// File: rtl/hc_queue.sv
// Guarded single-clock FIFO with level, warning threshold and sticky errors.
// HC_QUEUE_REGOUT_EN selects a registered head output instead of fall-through.
module hc_queue
    import hc_queue_pkg::*;
#(
    parameter int DATABITS       = HC_DATABITS,
    parameter int QUEUECNTBITS   = HC_QUEUECNTBITS,
    parameter int QUEUESIZE      = 2**QUEUECNTBITS,
    parameter int QUEUEWARNLEVEL = QUEUESIZE - 3
) (
    input  logic       clk,
    input  logic       reset_n,
    hc_queue_if.slave  q
);

    localparam int LVLW = level_bits(QUEUECNTBITS);

    logic [QUEUECNTBITS-1:0] inaddr;
    logic [QUEUECNTBITS-1:0] outaddr;
    logic [LVLW-1:0]         level;
    logic [LVLW-1:0]         level_next;
    hc_err_t                 err_q;
    hc_err_t                 err_d;
    logic                    full;
    logic                    not_empty;
    logic                    do_push;
    logic                    do_pop;
    logic                    adv_out;

    // Full/empty come from the level only; pointer equality is ambiguous.
    assign full     = (level == LVLW'(QUEUESIZE));
    assign do_pop   = q.queue_pop & not_empty;
    assign do_push  = q.queue_push & (~full | do_pop);

    assign q.queue_full      = full;
    assign q.queue_warning   = (level >= LVLW'(QUEUEWARNLEVEL));
    assign q.queue_not_empty = not_empty;
    assign q.queue_level     = level;
    assign q.queue_overflow  = err_q.overflow;
    assign q.queue_underflow = err_q.underflow;

    always_comb begin
        level_next = level + LVLW'(do_push) - LVLW'(do_pop);
        err_d      = err_q;
        if (q.queue_clr_err) err_d = '0;
        if (q.queue_push & full & ~do_pop) err_d.overflow  = 1'b1;
        if (q.queue_pop & ~not_empty)      err_d.underflow = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inaddr  <= '0;
            outaddr <= '0;
            level   <= '0;
            err_q   <= '0;
        end else begin
            if (do_push) inaddr  <= inaddr + 1'b1;
            if (adv_out) outaddr <= outaddr + 1'b1;
            level <= level_next;
            err_q <= err_d;
        end
    end

`ifdef HC_QUEUE_REGOUT_EN
    logic            out_vld_p1;
    logic [LVLW-1:0] mem_cnt;
    logic            load_p0;

    // The head lives in the output register; RAM holds the remaining entries.
    assign mem_cnt   = level - LVLW'(out_vld_p1);
    assign load_p0   = (mem_cnt != '0) & (~out_vld_p1 | do_pop);
    assign adv_out   = load_p0;
    assign not_empty = out_vld_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     out_vld_p1 <= 1'b0;
        else if (load_p0) out_vld_p1 <= 1'b1;
        else if (do_pop)  out_vld_p1 <= 1'b0;
    end
`else
    assign adv_out   = do_pop;
    assign not_empty = (level != '0);
`endif

    // Write is gated by reset so nothing lands in memory once reset_n falls.
    hc_queue_ram #(
        .DATABITS (DATABITS),
        .ADDRBITS (QUEUECNTBITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (do_push & reset_n),
        .wr_addr (inaddr),
        .wr_data (q.queue_in),
`ifdef HC_QUEUE_REGOUT_EN
        .rd_en   (load_p0),
`endif
        .rd_addr (outaddr),
        .rd_data (q.queue_out)
    );

endmodule

// File: tb/tb_hc_queue.sv
// Directed bench for hc_queue: vector table for fill/overflow/drain plus
// hand sequences for full push+pop, underflow, wrap-around and async reset.
module tb_hc_queue;
    import hc_queue_pkg::*;

    localparam int DB  = 8;
    localparam int QCB = 4;
`ifdef HC_QUEUE_REGOUT_EN
    localparam logic FIRST_NE = 1'b0;
`else
    localparam logic FIRST_NE = 1'b1;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hc_queue_if #(.DATABITS(DB), .QUEUECNTBITS(QCB)) qif ();

    hc_queue #(.DATABITS(DB), .QUEUECNTBITS(QCB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (qif.slave)
    );

    typedef struct {
        logic       push;
        logic       pop;
        logic       clr;
        logic [7:0] din;
        logic       chk_out;
        logic [7:0] exp_out;
        logic [4:0] exp_level;
        logic       exp_ne;
        logic       exp_full;
        logic       exp_warn;
        logic       exp_ovf;
        logic       exp_udf;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] model[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic vec_t mkvec(input logic push, input logic pop, input logic clr,
                                   input logic [7:0] din, input logic chk_out,
                                   input logic [7:0] exp_out, input logic [4:0] lvl,
                                   input logic ne, input logic full, input logic warn,
                                   input logic ovf, input logic udf);
        vec_t v;
        v.push = push; v.pop = pop; v.clr = clr; v.din = din;
        v.chk_out = chk_out; v.exp_out = exp_out; v.exp_level = lvl;
        v.exp_ne = ne; v.exp_full = full; v.exp_warn = warn;
        v.exp_ovf = ovf; v.exp_udf = udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic [4:0] lvl, input logic ne,
                              input logic full, input logic warn, input logic ovf,
                              input logic udf);
        chk({tag, "_level"}, 32'(qif.queue_level), 32'(lvl));
        chk({tag, "_ne"},    32'(qif.queue_not_empty), 32'(ne));
        chk({tag, "_full"},  32'(qif.queue_full), 32'(full));
        chk({tag, "_warn"},  32'(qif.queue_warning), 32'(warn));
        chk({tag, "_ovf"},   32'(qif.queue_overflow), 32'(ovf));
        chk({tag, "_udf"},   32'(qif.queue_underflow), 32'(udf));
    endtask

    task automatic step(input logic push, input logic pop, input logic clr, input logic [7:0] din);
        qif.queue_push    = push;
        qif.queue_pop     = pop;
        qif.queue_clr_err = clr;
        qif.queue_in      = din;
        @(posedge clk);
        #1;
        qif.queue_push    = 1'b0;
        qif.queue_pop     = 1'b0;
        qif.queue_clr_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npush;
        int it;
        logic p_push;
        logic p_pop;
        logic [7:0] d;

        qif.queue_push = 1'b0; qif.queue_pop = 1'b0;
        qif.queue_clr_err = 1'b0; qif.queue_in = '0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk_status("in_reset", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        chk_status("idle", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Table: fill 16, overflow push, drain 16, clear error
        for (int i = 0; i < 16; i++)
            vecs.push_back(mkvec(1'b1, 1'b0, 1'b0, 8'(i + 1), 1'b0, 8'h00, 5'(i + 1),
                                 (i == 0) ? FIRST_NE : 1'b1, (i == 15), (i + 1 >= 13),
                                 1'b0, 1'b0));
        vecs.push_back(mkvec(1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 8'h00, 5'd16,
                             1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 16; k++)
            vecs.push_back(mkvec(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'(k + 1), 5'(15 - k),
                                 (k != 15), 1'b0, (15 - k >= 13), 1'b1, 1'b0));
        vecs.push_back(mkvec(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 5'd0,
                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            if (vecs[i].chk_out)
                chk($sformatf("v%0d_out", i), 32'(qif.queue_out), 32'(vecs[i].exp_out));
            step(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
            chk_status($sformatf("v%0d", i), vecs[i].exp_level, vecs[i].exp_ne,
                       vecs[i].exp_full, vecs[i].exp_warn, vecs[i].exp_ovf, vecs[i].exp_udf);
        end

        // Full queue: push together with pop is accepted
        model.delete();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
            model.push_back(8'(8'h20 + i));
        end
        chk("fullpp_pre_level", 32'(qif.queue_level), 32'd16);
        chk("fullpp_head", 32'(qif.queue_out), 32'(model[0]));
        step(1'b1, 1'b1, 1'b0, 8'h55);
        void'(model.pop_front());
        model.push_back(8'h55);
        chk("fullpp_level", 32'(qif.queue_level), 32'd16);
        chk("fullpp_full", 32'(qif.queue_full), 32'd1);
        chk("fullpp_ovf", 32'(qif.queue_overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fullpp_out%0d", i), 32'(qif.queue_out), 32'(model[0]));
            void'(model.pop_front());
            step(1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk("fullpp_end_level", 32'(qif.queue_level), 32'd0);

        // Underflow and clear
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("udf_flag", 32'(qif.queue_underflow), 32'd1);
        chk("udf_level", 32'(qif.queue_level), 32'd0);
        chk("udf_ne", 32'(qif.queue_not_empty), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("udf_clr", 32'(qif.queue_underflow), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h77);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("udf_ptr_out", 32'(qif.queue_out), 32'h77);
        chk("udf_ptr_level", 32'(qif.queue_level), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("udf_drain_level", 32'(qif.queue_level), 32'd0);

        // Wrap-around stream with level kept in 2..5
        for (int j = 0; j < 3; j++) begin
            step(1'b1, 1'b0, 1'b0, 8'(8'h80 + j));
            model.push_back(8'(8'h80 + j));
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        npush = 0;
        it = 0;
        while (npush < 40 && it < 200) begin
            p_push = (model.size() <= 2) ? 1'b1 : (model.size() >= 5) ? 1'b0 : (it % 3 != 0);
            p_pop  = (model.size() >= 5) ? 1'b1 : (model.size() <= 2) ? 1'b0 : (it % 2 == 0);
            d = 8'(npush * 7 + 3);
            if (p_pop) chk("wrap_out", 32'(qif.queue_out), 32'(model[0]));
            step(p_push, p_pop, 1'b0, d);
            if (p_pop) void'(model.pop_front());
            if (p_push) begin
                model.push_back(d);
                npush++;
            end
            chk("wrap_level", 32'(qif.queue_level), 32'(model.size()));
            it++;
        end
        chk("wrap_pushes", 32'(npush), 32'd40);
        while (model.size() > 0) begin
            chk("wrap_drain_out", 32'(qif.queue_out), 32'(model[0]));
            void'(model.pop_front());
            step(1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk("wrap_drain_level", 32'(qif.queue_level), 32'd0);

        // Asynchronous reset mid-stream at level 7
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        chk("rst_pre_level", 32'(qif.queue_level), 32'd7);
        qif.queue_push = 1'b1;
        qif.queue_in   = 8'h99;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_level", 32'(qif.queue_level), 32'd0);
        chk("rst_async_ne", 32'(qif.queue_not_empty), 32'd0);
        qif.queue_push = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h3C);
        chk("rst_push_level", 32'(qif.queue_level), 32'd1);
        chk("rst_push_ne", 32'(qif.queue_not_empty), 32'(FIRST_NE));
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_read_ne", 32'(qif.queue_not_empty), 32'd1);
        chk("rst_read_out", 32'(qif.queue_out), 32'h3C);
        chk("rst_read_level", 32'(qif.queue_level), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hc_queue.md
Name: hc_queue

Overview:
- Parametrised successor FIFO for the hybrid cache request/response paths.
- Single-clock circular buffer with correct full and empty tracking, and a level output one bit wider than the pointers so that a full queue is representable.
- Programmable warning threshold.
- Guarded push/pop: ignored when they would overflow or underflow, with sticky error flags.
- Sits between cache front-end and memory controller wherever back-pressure needs early warning.

Parameters:
- DATABITS, 8, width of one queue entry.
- QUEUECNTBITS, 4, pointer width; depth = 2**QUEUECNTBITS.
- QUEUESIZE, 2**QUEUECNTBITS, derived depth; must not be overridden.
- QUEUEWARNLEVEL, QUEUESIZE-3, queue_warning asserts when level >= this value; legal range 1..QUEUESIZE.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- queue_in  input  DATABITS  push data.
- queue_push  input  1  push request.
- queue_full  output  1  level == QUEUESIZE.
- queue_warning  output  1  level >= QUEUEWARNLEVEL.
- queue_pop  input  1  pop request; consumes the entry currently on queue_out.
- queue_out  output  DATABITS  head entry (first-word-fall-through).
- queue_not_empty  output  1  head entry valid.
- queue_level  output  QUEUECNTBITS+1  current entry count, 0..QUEUESIZE.
- queue_overflow  output  1  sticky: push attempted while full and not popping.
- queue_underflow  output  1  sticky: pop attempted while empty.
- queue_clr_err  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (async assert, sync-released by the system):
  - inaddr, outaddr and level go to 0.
  - queue_not_empty = 0, queue_full = 0, queue_warning = 0.
  - queue_overflow = 0, queue_underflow = 0.
  - Memory contents are not cleared. queue_out is don't-care while empty.
- Accepted push (do_push):
  - do_push = queue_push & (!queue_full | do_pop).
  - Writes queue_in to mem[inaddr]; inaddr increments modulo QUEUESIZE (natural wrap).
- Accepted pop (do_pop):
  - do_pop = queue_pop & queue_not_empty.
  - outaddr increments modulo QUEUESIZE.
- Level update:
  - level_next = level + do_push - do_pop, evaluated in QUEUECNTBITS+1 bits.
  - Push and pop in the same cycle leave level unchanged.
  - Push while full is accepted only together with a pop.
- Rejected requests:
  - Push while full without a pop sets queue_overflow. Data is dropped and no pointer moves.
  - Pop while empty sets queue_underflow. No pointer moves.
- Sticky flags:
  - Stay set until queue_clr_err or reset.
  - If clr and a new error occur in the same cycle, set wins.
- Latency (macro off):
  - Push at edge N gives queue_not_empty = 1 and valid queue_out after edge N.
  - Pop at edge N presents the next entry after edge N.
- Status outputs: queue_full, queue_warning and queue_not_empty are combinational decodes of the registered level and are glitch-free relative to clk.
- Full/empty decisions come from level only, never from pointer equality. inaddr == outaddr is ambiguous at full.
- Reset asserted mid-burst aborts immediately. No partial write completes after reset_n falls.

Optional Feature:
- Macro: HC_QUEUE_REGOUT_EN.
- Defined:
  - queue_out is driven from a dedicated output register loaded from memory (RAM read is registered).
  - queue_not_empty means "output register valid".
  - Push into an empty queue gives queue_not_empty = 1 one cycle later (two edges after the push).
  - queue_level still counts all entries, including the one in the output register.
  - Full/overflow rules are unchanged.
- Undefined: combinational read, as described in Behaviour.

Decomposition:
- Package hc_queue_pkg holds:
  - the level-width helper function (QUEUECNTBITS+1);
  - the default DATABITS/QUEUECNTBITS localparams shared by the cache queues;
  - an error-flag struct/typedef {overflow, underflow}.
- One sub-module, hc_queue_ram:
  - simple dual-port storage, write port and read port;
  - asynchronous read when HC_QUEUE_REGOUT_EN is off, registered read when it is on.
- Pointer, level and flag logic stay in hc_queue.

Test Plan:
- Reset then idle (DATABITS=8, QUEUECNTBITS=4):
  - Required: level = 0, not_empty = 0, full = 0, warning = 0, both error flags 0.
- Push 0x01..0x10 on 16 consecutive cycles:
  - Warning rises at level 13; full = 1 at level 16.
  - 17th push of 0xAA sets queue_overflow; level stays 16.
  - Popping 16 times returns 0x01..0x10 in order.
- Fill to 16, then push 0x55 together with a pop in one cycle:
  - Push is accepted, level stays 16, no overflow.
  - Last entry popped out is 0x55.
- Pop on an empty queue:
  - queue_underflow = 1 and pointers unchanged.
  - Assert queue_clr_err for one cycle: flag returns to 0.
- Wrap-around:
  - Stream 40 pushes interleaved with pops, keeping level between 2 and 5.
  - Required: output order equals input order across pointer wrap, and level matches the model every cycle.
- Drop reset_n mid-stream at level 7:
  - Required: level goes to 0 and not_empty goes to 0 asynchronously.
  - After release, a push of 0x3C is read back as 0x3C with level = 1.
  - With HC_QUEUE_REGOUT_EN defined, not_empty rises one cycle later than without it.
